pipe_ctrl_track: RTL and testbench

Parametrised control-pipeline tracker for the pipelined core. It carries per-instruction control payloads from Decode through STAGES registered stages (default E, M, W) with independent per-stage stall and flush, and gates write enables on the condition result at a configurable stage. It inserts bubbles automatically when a younger stage stalls and an older stage does not. It also tracks pending PC writes and pending destination-register writes for the hazard unit.

---
 rtl/pipe_ctrl_track.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl_track.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_track.sv
// Control-pipeline tracker: carries Decode payloads through STAGES stages with stall/flush, bubbles, cond gate.
// Latency 1 cycle per stage; stall[i] holds stage i, and a stalled predecessor feeds a bubble to an unstalled successor.
// Optional rd scoreboard (busy_rd, hazard_a/b) enabled by PIPE_CTRL_TRACK_SCOREBOARD_EN.
module pipe_ctrl_track #(
  parameter int                STAGES     = 3,
  parameter int                CTRL_W     = 8,
  parameter int                COND_STAGE = 0,
  parameter logic [CTRL_W-1:0] GATE_MASK  = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_d,
  input  logic [CTRL_W-1:0]          ctrl_d,
  input  logic                       wr_d,
  input  logic [3:0]                 rd_d,
  input  logic                       pcwr_d,
  input  logic                       condpass,
  input  logic [STAGES-1:0]          stall,
  input  logic [STAGES-1:0]          flush,
  output logic [STAGES-1:0]          valid_q,
  output logic [STAGES*CTRL_W-1:0]   ctrl_q,
  output logic [STAGES-1:0]          wr_q,
  output logic                       pcwr_pending,
  output logic [15:0]                busy_rd,
  input  logic [3:0]                 src_a,
  input  logic [3:0]                 src_b,
  output logic                       hazard_a,
  output logic                       hazard_b
);

  logic [STAGES-1:0]             stg_valid_q, stg_valid_d;
  logic [STAGES-1:0][CTRL_W-1:0] stg_ctrl_q,  stg_ctrl_d;
  logic [STAGES-1:0]             stg_wr_q,    stg_wr_d;
  logic [STAGES-1:0]             stg_pcwr_q,  stg_pcwr_d;

  logic [STAGES-1:0]             in_valid;
  logic [STAGES-1:0][CTRL_W-1:0] in_ctrl;
  logic [STAGES-1:0]             in_wr;
  logic [STAGES-1:0]             in_pcwr;
  logic [STAGES-1:0]             bubble;

  always_comb begin
    in_valid    = '0;
    in_ctrl     = '0;
    in_wr       = '0;
    in_pcwr     = '0;
    bubble      = '0;
    in_valid[0] = valid_d;
    in_ctrl[0]  = ctrl_d;
    in_wr[0]    = wr_d & valid_d;
    in_pcwr[0]  = pcwr_d & valid_d;
    for (int i = 1; i < STAGES; i++) begin
      in_valid[i] = stg_valid_q[i-1];
      in_ctrl[i]  = stg_ctrl_q[i-1];
      in_wr[i]    = stg_wr_q[i-1];
      in_pcwr[i]  = stg_pcwr_q[i-1];
      bubble[i]   = stall[i-1] & ~stall[i];
    end
    // Failed condition kills side effects on the way out of the condition stage.
    if (!condpass) begin
      in_wr[COND_STAGE+1]   = 1'b0;
      in_pcwr[COND_STAGE+1] = 1'b0;
      in_ctrl[COND_STAGE+1] = in_ctrl[COND_STAGE+1] & ~GATE_MASK;
    end

    stg_valid_d = stg_valid_q;
    stg_ctrl_d  = stg_ctrl_q;
    stg_wr_d    = stg_wr_q;
    stg_pcwr_d  = stg_pcwr_q;
    for (int i = 0; i < STAGES; i++) begin
      if (flush[i] || (!stall[i] && bubble[i])) begin
        stg_valid_d[i] = 1'b0;
        stg_ctrl_d[i]  = '0;
        stg_wr_d[i]    = 1'b0;
        stg_pcwr_d[i]  = 1'b0;
      end else if (!stall[i]) begin
        stg_valid_d[i] = in_valid[i];
        stg_ctrl_d[i]  = in_ctrl[i];
        stg_wr_d[i]    = in_wr[i];
        stg_pcwr_d[i]  = in_pcwr[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_valid_q <= '0;
      stg_ctrl_q  <= '0;
      stg_wr_q    <= '0;
      stg_pcwr_q  <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_ctrl_q  <= stg_ctrl_d;
      stg_wr_q    <= stg_wr_d;
      stg_pcwr_q  <= stg_pcwr_d;
    end
  end

  assign valid_q      = stg_valid_q;
  assign ctrl_q       = stg_ctrl_q;
  assign wr_q         = stg_wr_q;
  assign pcwr_pending = (pcwr_d & valid_d) | (|stg_pcwr_q);

`ifdef PIPE_CTRL_TRACK_SCOREBOARD_EN
  logic [STAGES-1:0][3:0] stg_rd_q, stg_rd_d;
  logic [15:0]            busy;

  always_comb begin
    stg_rd_d = stg_rd_q;
    for (int i = 0; i < STAGES; i++) begin
      if (flush[i] || (!stall[i] && bubble[i])) begin
        stg_rd_d[i] = 4'd0;
      end else if (!stall[i]) begin
        stg_rd_d[i] = (i == 0) ? rd_d : stg_rd_q[(i == 0) ? 0 : i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_rd_q <= '0;
    end else begin
      stg_rd_q <= stg_rd_d;
    end
  end

  // Last stage is excluded: its result is forwarded from the write port.
  always_comb begin
    busy = '0;
    for (int i = 0; i < STAGES-1; i++) begin
      if (stg_valid_q[i] && stg_wr_q[i]) busy[stg_rd_q[i]] = 1'b1;
    end
  end

  assign busy_rd  = busy;
  assign hazard_a = busy[src_a];
  assign hazard_b = busy[src_b];
`else
  logic unused_sb;
  assign unused_sb = ^{rd_d, src_a, src_b};
  assign busy_rd   = 16'h0000;
  assign hazard_a  = 1'b0;
  assign hazard_b  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_track.sv
// Bench for pipe_ctrl_track: directed scenarios then random traffic against an instruction-slot model.
module tb_pipe_ctrl_track;
  localparam int         S  = 3;
  localparam int         W  = 8;
  localparam int         CS = 0;
  localparam logic [7:0] GM = 8'h0F;
`ifdef PIPE_CTRL_TRACK_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic valid_d, wr_d, pcwr_d, condpass;
  logic [7:0] ctrl_d;
  logic [3:0] rd_d, src_a, src_b;
  logic [S-1:0] stall, flush;
  logic [S-1:0] valid_q, wr_q;
  logic [S*W-1:0] ctrl_q;
  logic pcwr_pending, hazard_a, hazard_b;
  logic [15:0] busy_rd;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       v;
    logic [7:0] c;
    logic       w;
    logic [3:0] r;
    logic       p;
  } slot_t;
  slot_t m [S];

  always #5 clk = ~clk;

  pipe_ctrl_track #(.STAGES(S), .CTRL_W(W), .COND_STAGE(CS), .GATE_MASK(GM)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .ctrl_d(ctrl_d), .wr_d(wr_d),
    .rd_d(rd_d), .pcwr_d(pcwr_d), .condpass(condpass), .stall(stall), .flush(flush),
    .valid_q(valid_q), .ctrl_q(ctrl_q), .wr_q(wr_q), .pcwr_pending(pcwr_pending),
    .busy_rd(busy_rd), .src_a(src_a), .src_b(src_b), .hazard_a(hazard_a), .hazard_b(hazard_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < S; i++) m[i] = '0;
  endtask

  task automatic check_all(input string tag);
    logic [S-1:0] ev, ew;
    logic [S*W-1:0] ec;
    logic ep;
    logic [15:0] eb;
    ev = '0; ew = '0; ec = '0; eb = '0;
    ep = pcwr_d & valid_d;
    for (int i = 0; i < S; i++) begin
      ev[i] = m[i].v;
      ew[i] = m[i].w;
      ec[i*W +: W] = m[i].c;
      ep = ep | m[i].p;
      if (SB && i < S-1 && m[i].v && m[i].w) eb[m[i].r] = 1'b1;
    end
    chk({tag, ".valid"}, 32'(valid_q), 32'(ev));
    chk({tag, ".ctrl"}, 32'(ctrl_q), 32'(ec));
    chk({tag, ".wr"}, 32'(wr_q), 32'(ew));
    chk({tag, ".pcwr_pending"}, 32'(pcwr_pending), 32'(ep));
    chk({tag, ".busy_rd"}, 32'(busy_rd), 32'(eb));
    chk({tag, ".hazard_a"}, 32'(hazard_a), 32'(eb[src_a]));
    chk({tag, ".hazard_b"}, 32'(hazard_b), 32'(eb[src_b]));
  endtask

  // One clock edge: each slot flushes, holds, takes a bubble or takes the older instruction.
  task automatic step(input string tag);
    slot_t n [S];
    slot_t src;
    for (int i = 0; i < S; i++) begin
      if (i == 0) begin
        src = {valid_d, ctrl_d, wr_d & valid_d, rd_d, pcwr_d & valid_d};
      end else begin
        src = m[i-1];
        if (i-1 == CS && !condpass) begin
          src.w = 1'b0;
          src.p = 1'b0;
          src.c = src.c & ~GM;
        end
      end
      if (!reset || flush[i])        n[i] = '0;
      else if (stall[i])             n[i] = m[i];
      else if (i > 0 && stall[i-1])  n[i] = '0;
      else                           n[i] = src;
    end
    @(posedge clk);
    m = n;
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    valid_d = 1'b0; ctrl_d = 8'h00; wr_d = 1'b0; rd_d = 4'd0; pcwr_d = 1'b0;
    condpass = 1'b1; stall = '0; flush = '0; src_a = 4'd0; src_b = 4'd0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    valid_d = 1'b1; ctrl_d = 8'hA5;
    clear_model();
    #2;
    check_all("rst_async");
    repeat (3) step("rst_hold");

    @(negedge clk);
    reset = 1'b1;
    repeat (3) step("rst_release");
    chk("rst_release.w_ctrl", 32'(ctrl_q[2*W +: W]), 32'h0000_00A5);

    idle_inputs();
    flush = 3'b111;
    step("gate_clr");
    flush = 3'b000;
    valid_d = 1'b1; ctrl_d = 8'hFF; wr_d = 1'b1; rd_d = 4'd3; pcwr_d = 1'b1;
    step("gate_issue");
    chk("gate_e_pcwr", 32'(pcwr_pending), 32'd1);
    idle_inputs();
    condpass = 1'b0;
    step("gate_m");
    chk("gate_m_valid", 32'(valid_q[1]), 32'd1);
    chk("gate_m_wr", 32'(wr_q[1]), 32'd0);
    chk("gate_m_ctrl", 32'(ctrl_q[W +: W]), 32'h0000_00F0);
    chk("gate_m_pcwr", 32'(pcwr_pending), 32'd0);
    condpass = 1'b1;

    for (int k = 0; k < 3; k++) begin
      valid_d = 1'b1; ctrl_d = 8'(8'h10 + k); wr_d = 1'b1; rd_d = 4'(k);
      step("bub_fill");
    end
    stall = 3'b001;
    for (int k = 0; k < 2; k++) begin
      ctrl_d = 8'h40;
      step("bub_stall");
      chk("bub_m_bubble", 32'(valid_q[1]), 32'd0);
      chk("bub_e_held", 32'(ctrl_q[7:0]), 32'h0000_0012);
    end
    stall = 3'b000;
    step("bub_release");

    ctrl_d = 8'h55;
    step("fos_fill");
    stall = 3'b011; flush = 3'b010;
    step("fos");
    chk("fos_m_cleared", 32'(valid_q[1]), 32'd0);
    chk("fos_e_held", 32'(ctrl_q[7:0]), 32'h0000_0055);

    idle_inputs();
    flush = 3'b111;
    step("sb_clr");
    flush = 3'b000;
    valid_d = 1'b1; wr_d = 1'b1; rd_d = 4'd7; src_a = 4'd7; ctrl_d = 8'h77;
    step("sb_e");
    chk("sb_haz_e", 32'(hazard_a), 32'(SB));
    valid_d = 1'b0; wr_d = 1'b0;
    step("sb_m");
    chk("sb_haz_m", 32'(hazard_a), 32'(SB));
    step("sb_w");
    chk("sb_haz_w", 32'(hazard_a), 32'd0);

    idle_inputs();
    repeat (2) step("pc_drain");
    valid_d = 1'b1; pcwr_d = 1'b1;
    #1;
    chk("pc_b2b_0", 32'(pcwr_pending), 32'd1);
    step("pc_b2b");
    chk("pc_b2b_1", 32'(pcwr_pending), 32'd1);
    idle_inputs();
    valid_d = 1'b1; pcwr_d = 1'b1;
    step("pc_b2b");
    chk("pc_b2b_2", 32'(pcwr_pending), 32'd1);
    idle_inputs();
    for (int k = 3; k < 5; k++) begin
      step("pc_b2b");
      chk("pc_b2b_tail", 32'(pcwr_pending), 32'd1);
    end
    step("pc_b2b");
    chk("pc_b2b_done", 32'(pcwr_pending), 32'd0);

    for (int k = 0; k < 400; k++) begin
      valid_d  = 1'($urandom);
      ctrl_d   = 8'($urandom);
      wr_d     = 1'($urandom);
      rd_d     = 4'($urandom);
      pcwr_d   = ($urandom_range(0, 3) == 0);
      condpass = 1'($urandom);
      stall    = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      flush    = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      src_a    = 4'($urandom);
      src_b    = 4'($urandom);
      step("rand");
    end

    @(negedge clk);
    #2;
    reset = 1'b0;
    clear_model();
    #1;
    check_all("rst_mid");
    step("rst_mid_hold");
    @(negedge clk);
    reset = 1'b1;
    valid_d = 1'b1; ctrl_d = 8'h3C; stall = '0; flush = '0;
    step("rst_mid_release");
    chk("rst_mid_e_ctrl", 32'(ctrl_q[7:0]), 32'h0000_003C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
